// File: rtl/regfile_loader_pkg.sv
// Shared definitions for the regfile loader: state encoding, command field
// positions and the register address stepping rule.
package regfile_loader_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;

    localparam int unsigned START_LSB = 0;

    // Opcode sits in the top bit of the command byte.
    function automatic int unsigned op_bit(input int unsigned width);
        return width - 32'd1;
    endfunction

    // Register count field sits directly above the start address field.
    function automatic int unsigned cnt_lsb(input int unsigned regbits);
        return regbits;
    endfunction

    // Step to the next register; register 0 is never targeted, so the top wraps to 1.
    function automatic int unsigned next_reg_addr(input int unsigned addr,
                                                  input int unsigned regbits);
        int unsigned top;
        top = (32'd1 << regbits) - 32'd1;
        return (addr >= top) ? 32'd1 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/regfile_loader_if.sv
// Command/data input stream and dump output stream of the regfile loader.
interface regfile_loader_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/regfile_loader.sv
// Host-side loader/dumper for the register file: decodes command bytes, streams
// load data into the write port and dumps registers from one read port.
module regfile_loader
    import regfile_loader_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    regfile_loader_if.slave    bus,
    output logic               active,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic [REGBITS-1:0] ra,
    input  logic [WIDTH-1:0]   rd
);

    localparam int unsigned OP_BIT  = op_bit(WIDTH);
    localparam int unsigned CNT_LSB = cnt_lsb(REGBITS);

    logic [1:0]         state, state_nxt;
    logic [REGBITS-1:0] addr, addr_nxt;
    logic [REGBITS-1:0] remaining, remaining_nxt;
    logic               out_valid_q, out_valid_nxt;
    logic [WIDTH-1:0]   out_data_q, out_data_nxt;

    logic               cmd_op;
    logic [REGBITS-1:0] cmd_cnt;
    logic [REGBITS-1:0] cmd_start;
    logic [REGBITS-1:0] addr_inc;
    logic               dump_load;

    assign cmd_op    = bus.in_data[OP_BIT];
    assign cmd_cnt   = bus.in_data[CNT_LSB +: REGBITS];
    assign cmd_start = bus.in_data[START_LSB +: REGBITS];
    assign addr_inc  = REGBITS'(next_reg_addr(32'(addr), REGBITS));

    // The one-entry output register may refill whenever it is empty or draining.
    assign dump_load = (!out_valid_q || bus.out_ready) && (remaining != '0);

    assign bus.in_ready  = (state != S_DUMP);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign active        = (state != S_IDLE);

    // Load data goes straight to the write port so the regfile writes on the accepting edge.
    assign regwrite = (state == S_LOAD) && bus.in_valid;
    assign wa       = (state == S_LOAD) ? addr : '0;
    assign wd       = (state == S_LOAD) ? bus.in_data : '0;
    assign ra       = (state == S_DUMP) ? addr : '0;

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;

        case (state)
            S_IDLE: begin
                if (bus.in_valid && (cmd_cnt != '0)) begin
                    addr_nxt      = (cmd_start == '0) ? REGBITS'(1) : cmd_start;
                    remaining_nxt = cmd_cnt;
                    state_nxt     = cmd_op ? S_LOAD : S_DUMP;
                end
            end

            S_LOAD: begin
                if (bus.in_valid) begin
                    addr_nxt      = addr_inc;
                    remaining_nxt = remaining - REGBITS'(1);
                    if (remaining == REGBITS'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_DUMP: begin
                if (dump_load) begin
                    out_data_nxt  = rd;
                    out_valid_nxt = 1'b1;
                    addr_nxt      = addr_inc;
                    remaining_nxt = remaining - REGBITS'(1);
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                end
                // Leave once nothing is left to read and the last byte is handed off.
                if ((remaining == '0) && (!out_valid_q || bus.out_ready)) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            addr        <= REGBITS'(1);
            remaining   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= remaining_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: acts as the regfile, drives command streams and
// checks write/dump traffic against an address-sequence model of the protocol.
module tb_regfile_loader;

    localparam int unsigned W    = 8;
    localparam int unsigned RB   = 3;
    localparam int          NREG = 8;

    typedef int iq_t[$];

    logic          clk;
    logic          reset;
    logic          active;
    logic          regwrite;
    logic [RB-1:0] wa;
    logic [W-1:0]  wd;
    logic [RB-1:0] ra;
    logic [W-1:0]  rd;

    regfile_loader_if #(.WIDTH(W)) bus ();

    regfile_loader #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .active   (active),
        .regwrite (regwrite),
        .wa       (wa),
        .wd       (wd),
        .ra       (ra),
        .rd       (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile stand-in owned by the bench.
    logic [W-1:0] rf [NREG];
    always @(posedge clk) if (regwrite) rf[wa] <= wd;
    assign rd = rf[ra];

    int ref_rf [NREG];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Traffic monitor, sampled mid-cycle.
    iq_t wa_q, wd_q, wc_q, od_q, oc_q;
    bit  dumping   = 0;
    bit  stalled   = 0;
    int  held      = 0;
    int  stab_err  = 0;
    int  stall_cnt = 0;
    int  dump_err  = 0;
    int  idle_err  = 0;

    always @(negedge clk) begin
        if (regwrite === 1'b1) begin
            wa_q.push_back(int'(wa));
            wd_q.push_back(int'(wd));
            wc_q.push_back(cyc);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            od_q.push_back(int'(bus.out_data));
            oc_q.push_back(cyc);
        end
        if (stalled && (bus.out_valid !== 1'b1 || int'(bus.out_data) != held)) stab_err++;
        stalled = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        held    = int'(bus.out_data);
        if (stalled) stall_cnt++;
        if (dumping && active && (bus.in_ready !== 1'b0 || regwrite !== 1'b0 ||
                                  wa !== '0 || wd !== '0)) dump_err++;
        if (!reset && active === 1'b0 && (ra !== '0 || regwrite !== 1'b0 || bus.out_valid !== 1'b0))
            idle_err++;
    end

    // Model: registers visited by a command with the given start and count.
    function automatic iq_t exp_addrs(input int start, input int cnt);
        iq_t q;
        int  a;
        a = (start == 0) ? 1 : start;
        for (int i = 0; i < cnt; i++) begin
            q.push_back(a);
            a = (a % (NREG - 1)) + 1;
        end
        return q;
    endfunction

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); od_q.delete(); oc_q.delete();
    endtask

    // Offer one byte and hold it until accepted; returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: byte %02h not accepted within 64 cycles", b);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (active === 1'b0) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: active still %b after 200 cycles", active);
        end
        @(posedge clk); #1;
    endtask

    // Drain a running dump, optionally with random backpressure.
    task automatic drain_dump(input bit rand_ready);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (active === 1'b0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dump_timeout: dump did not finish within 200 cycles");
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (active !== 1'b0 || bus.in_ready !== 1'b1 || regwrite !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: active=%b in_ready=%b regwrite=%b out_valid=%b want 0 1 0 0",
                     active, bus.in_ready, regwrite, bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== '0 || wa !== '0 || wd !== '0 || ra !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h wa=%0d wd=%h ra=%0d want all 0",
                     bus.out_data, wa, wd, ra);
        end
        @(posedge clk); #1;
    endtask

    // Give every register a known random value through the loader.
    task automatic test_fill();
        int v [NREG];
        clear_mon();
        send_byte(8'hB9);
        for (int i = 1; i < NREG; i++) begin
            v[i] = int'($urandom_range(0, 255));
            send_byte(8'(v[i]));
        end
        wait_idle();
        n_checks++;
        if (wa_q.size() != NREG - 1) begin
            n_fail++;
            $display("FAIL fill_count: got %0d writes want %0d", wa_q.size(), NREG - 1);
        end
        for (int i = 1; i < NREG; i++) begin
            ref_rf[i] = v[i];
            n_checks++;
            if (int'(rf[i]) != ref_rf[i]) begin
                n_fail++;
                $display("FAIL fill_rf[%0d]: got %02h want %02h", i, rf[i], ref_rf[i]);
            end
        end
    endtask

    task automatic test_load_basic();
        iq_t ea;
        int  dv [3] = '{8'h11, 8'h22, 8'h33};
        ea = exp_addrs(2, 3);
        clear_mon();
        send_byte(8'h9A);
        foreach (dv[i]) send_byte(8'(dv[i]));
        @(negedge clk);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL load_basic_active: got %b want 0 after last byte", active);
        end
        n_checks++;
        if (wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL load_basic_count: got %0d writes want 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wa_q[i] != ea[i] || wd_q[i] != dv[i] || wc_q[i] != wc_q[0] + i) begin
                    n_fail++;
                    $display("FAIL load_basic_w%0d: wa=%0d wd=%02h cyc+%0d want wa=%0d wd=%02h cyc+%0d",
                             i, wa_q[i], wd_q[i], wc_q[i] - wc_q[0], ea[i], dv[i], i);
                end
            end
        end
        foreach (dv[i]) ref_rf[ea[i]] = dv[i];
        for (int i = 2; i <= 4; i++) begin
            n_checks++;
            if (int'(rf[i]) != ref_rf[i]) begin
                n_fail++;
                $display("FAIL load_basic_rf[%0d]: got %02h want %02h", i, rf[i], ref_rf[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        iq_t ea;
        int  dv [3] = '{8'hA6, 8'hA7, 8'hA1};
        ea = exp_addrs(6, 3);
        clear_mon();
        send_byte(8'h9E);
        foreach (dv[i]) send_byte(8'(dv[i]));
        wait_idle();
        foreach (dv[i]) ref_rf[ea[i]] = dv[i];
        n_checks++;
        if (wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes want 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wa_q[i] != ea[i] || wd_q[i] != dv[i]) begin
                    n_fail++;
                    $display("FAIL wrap_w%0d: wa=%0d wd=%02h want wa=%0d wd=%02h",
                             i, wa_q[i], wd_q[i], ea[i], dv[i]);
                end
            end
        end
        clear_mon();
        send_byte(8'h88);
        send_byte(8'h5C);
        wait_idle();
        ref_rf[1] = 8'h5C;
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] != 1 || wd_q[0] != 8'h5C) begin
            n_fail++;
            $display("FAIL start_zero: writes=%0d wa=%0d wd=%02h want 1 write wa=1 wd=5c",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1, (wd_q.size() > 0) ? wd_q[0] : -1);
        end
    endtask

    task automatic test_dump_backpressure();
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        iq_t ea;
        ea = exp_addrs(2, 3);
        clear_mon();
        stab_err  = 0;
        stall_cnt = 0;
        dump_err  = 0;
        dumping   = 1;
        bus.out_ready = 1'b1;
        send_byte(8'h1A);
        foreach (pat[i]) begin
            bus.out_ready = pat[i];
            @(posedge clk); #1;
        end
        drain_dump(1'b0);
        dumping = 0;
        n_checks++;
        if (od_q.size() != 3) begin
            n_fail++;
            $display("FAIL dump_bp_count: got %0d bytes want 3", od_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (od_q[i] != ref_rf[ea[i]]) begin
                    n_fail++;
                    $display("FAIL dump_bp_b%0d: got %02h want %02h", i, od_q[i], ref_rf[ea[i]]);
                end
            end
        end
        n_checks++;
        if (stab_err != 0 || stall_cnt != 2) begin
            n_fail++;
            $display("FAIL dump_bp_hold: unstable=%0d stalls=%0d want 0 and 2", stab_err, stall_cnt);
        end
        n_checks++;
        if (dump_err != 0) begin
            n_fail++;
            $display("FAIL dump_bp_ports: %0d cycles with in_ready/regwrite/wa/wd active in dump", dump_err);
        end
    endtask

    task automatic test_cnt_zero();
        clear_mon();
        send_byte(8'h83);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (active !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL cnt_zero_c%0d: active=%b in_ready=%b want 0 1", i, active, bus.in_ready);
            end
        end
        n_checks++;
        if (wa_q.size() != 0 || od_q.size() != 0) begin
            n_fail++;
            $display("FAIL cnt_zero_traffic: writes=%0d outputs=%0d want 0 0", wa_q.size(), od_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        iq_t ea;
        clear_mon();
        send_byte(8'h9A);
        send_byte(8'h11);
        ref_rf[2] = 8'h11;
        reset = 1'b1;
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.in_data  = 8'h22;
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (active !== 1'b0 || regwrite !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: active=%b regwrite=%b out_valid=%b in_ready=%b want 0 0 0 1",
                     active, regwrite, bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        dumping = 1;
        drain_dump(1'b0);
        dumping = 0;
        ea = exp_addrs(2, 4);
        n_checks++;
        if (wa_q.size() != 1 || od_q.size() != 4) begin
            n_fail++;
            $display("FAIL reset_mid_traffic: writes=%0d outputs=%0d want 1 4", wa_q.size(), od_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (od_q[i] != ref_rf[ea[i]]) begin
                    n_fail++;
                    $display("FAIL reset_mid_b%0d: got %02h want %02h", i, od_q[i], ref_rf[ea[i]]);
                end
            end
        end
    endtask

    task automatic test_full_rate();
        send_byte(8'hB9);
        for (int i = 1; i < NREG; i++) begin
            send_byte(8'(i));
            ref_rf[i] = i;
        end
        wait_idle();
        clear_mon();
        bus.out_ready = 1'b1;
        dumping = 1;
        send_byte(8'h38);
        drain_dump(1'b0);
        dumping = 0;
        n_checks++;
        if (od_q.size() != 7) begin
            n_fail++;
            $display("FAIL full_rate_count: got %0d bytes want 7", od_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (od_q[i] != i + 1 || oc_q[i] != oc_q[0] + i) begin
                    n_fail++;
                    $display("FAIL full_rate_b%0d: data=%02h cyc+%0d want data=%02h cyc+%0d",
                             i, od_q[i], oc_q[i] - oc_q[0], i + 1, i);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        int  op, cnt, start, v;
        iq_t ea, dv;
        stab_err = 0;
        dump_err = 0;
        idle_err = 0;
        for (int t = 0; t < 40; t++) begin
            op    = int'($urandom_range(0, 1));
            cnt   = int'($urandom_range(0, 7));
            start = int'($urandom_range(0, 7));
            cmd   = {1'(op), 1'($urandom_range(0, 1)), 3'(cnt), 3'(start)};
            ea    = exp_addrs(start, cnt);
            dv.delete();
            clear_mon();
            if (op == 1) begin
                send_byte(cmd);
                for (int i = 0; i < cnt; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    v = int'($urandom_range(0, 255));
                    dv.push_back(v);
                    send_byte(8'(v));
                end
                wait_idle();
                foreach (ea[i]) ref_rf[ea[i]] = dv[i];
                n_checks++;
                if (wa_q.size() != cnt || od_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_load_count: cmd=%02h writes=%0d outputs=%0d want %0d 0",
                             t, cmd, wa_q.size(), od_q.size(), cnt);
                end else begin
                    foreach (ea[i]) begin
                        n_checks++;
                        if (wa_q[i] != ea[i] || wd_q[i] != dv[i]) begin
                            n_fail++;
                            $display("FAIL rand%0d_w%0d: cmd=%02h wa=%0d wd=%02h want wa=%0d wd=%02h",
                                     t, i, cmd, wa_q[i], wd_q[i], ea[i], dv[i]);
                        end
                    end
                end
            end else begin
                dumping = 1;
                send_byte(cmd);
                drain_dump(1'b1);
                dumping = 0;
                n_checks++;
                if (od_q.size() != cnt || wa_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_dump_count: cmd=%02h outputs=%0d writes=%0d want %0d 0",
                             t, cmd, od_q.size(), wa_q.size(), cnt);
                end else begin
                    foreach (ea[i]) begin
                        n_checks++;
                        if (od_q[i] != ref_rf[ea[i]]) begin
                            n_fail++;
                            $display("FAIL rand%0d_b%0d: cmd=%02h got %02h want %02h (reg %0d)",
                                     t, i, cmd, od_q[i], ref_rf[ea[i]], ea[i]);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (stab_err != 0 || dump_err != 0 || idle_err != 0) begin
            n_fail++;
            $display("FAIL rand_protocol: unstable=%0d dump_port_err=%0d idle_port_err=%0d want 0 0 0",
                     stab_err, dump_err, idle_err);
        end
        for (int i = 1; i < NREG; i++) begin
            n_checks++;
            if (int'(rf[i]) != ref_rf[i]) begin
                n_fail++;
                $display("FAIL rand_rf[%0d]: got %02h want %02h", i, rf[i], ref_rf[i]);
            end
        end
    endtask

    initial begin
        foreach (ref_rf[i]) ref_rf[i] = 0;
        test_reset();
        test_fill();
        test_load_basic();
        test_wrap();
        test_dump_backpressure();
        test_cnt_zero();
        test_reset_mid();
        test_full_rate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
